// File: rtl/ifu_fetch_ctrl.sv
// Single-outstanding fetch sequencer that owns the PC. inst_valid rises one cycle after the memory
// response and holds until decode accepts it; redirects squash any fetch already in flight.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [31:0]      inst_pc4,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             halted,
  output logic             err_misalign,
  output logic [31:0]      err_pc,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             drop_q, drop_d;
  logic             hpend_q, hpend_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      err_pc_q, err_pc_d;

  logic halt_req, req_fire, inst_fire, redir_mis, redir_ok;

  assign halt_req  = halt | hpend_q;
  assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);

  // A pending halt withholds the request so no response can arrive after HALT is entered.
  assign imem_req_valid = !rst && (state_q == S_REQ) && !halt_req;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = !rst && (state_q == S_HOLD);
  assign halted         = !rst && (state_q == S_HALT);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_pc4       = inst_pc_q + 32'd4;
  assign err_misalign   = err_q;
  assign err_pc         = err_pc_q;
  assign fetch_count    = cnt_q;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign inst_fire = inst_valid && inst_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    hpend_d   = hpend_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    err_pc_d  = err_pc_q;

    if (inst_fire) cnt_d = cnt_q + CNT_W'(1);

    if (state_q != S_HALT) begin
      if (halt) hpend_d = 1'b1;
      if (redir_mis) begin
        err_d    = 1'b1;
        err_pc_d = redirect_pc;
        state_d  = S_HALT;
      end else if (redir_ok) begin
        pc_d = redirect_pc;
        unique case (state_q)
          S_REQ: begin
            if (req_fire) begin
              state_d = S_WAIT;
              drop_d  = 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              state_d = S_REQ;
              drop_d  = 1'b0;
            end else begin
              drop_d = 1'b1;
            end
          end
          S_HOLD:  state_d = S_REQ;
          default: state_d = state_q;
        endcase
      end else begin
        unique case (state_q)
          S_REQ: begin
            if (halt_req)            state_d = S_HALT;
            else if (imem_req_ready) state_d = S_WAIT;
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              if (drop_q || halt_req) begin
                drop_d  = 1'b0;
                state_d = halt_req ? S_HALT : S_REQ;
              end else begin
                inst_d    = imem_rsp_data;
                inst_pc_d = pc_q;
                state_d   = S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (inst_ready) begin
              pc_d    = pc_q + 32'd4;
              state_d = halt_req ? S_HALT : S_REQ;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      hpend_q   <= 1'b0;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_pc_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      hpend_q   <= hpend_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_pc_q  <= err_pc_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed and randomized bench for ifu_fetch_ctrl against a transaction-level fetch model.
module tb_ifu_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc, inst_pc4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt = 1'b0;
  logic        halted, err_misalign;
  logic [31:0] err_pc, fetch_count;

  ifu_fetch_ctrl #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .halted(halted),
    .err_misalign(err_misalign), .err_pc(err_pc), .fetch_count(fetch_count)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: architectural pc, one outstanding fetch, one delivered instruction awaiting decode.
  logic [31:0] m_pc, m_addr, d_pc, m_errpc, m_cnt, mem_addr;
  bit          m_out, m_stale, m_deliv, m_halted, m_hpend, m_err;
  bit          mem_pend;
  int          mem_cnt, lat, hs_seen;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    halt = 1'b0; imem_rsp_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_err", err_misalign, 0);
    chk("rst_err_pc", err_pc, 0);
    rst = 1'b0;
    m_pc = RPC; m_cnt = 0; m_out = 0; m_stale = 0; m_deliv = 0; m_halted = 0;
    m_hpend = 0; m_err = 0; m_errpc = 0; mem_pend = 0; mem_cnt = 0; hs_seen = 0;
  endtask

  task automatic cyc(input bit rrdy, input bit irdy, input bit rv, input logic [31:0] rpc, input bit hlt);
    bit hp, mis, red, exp_req, req_fire, inst_fire, rsp, idle, mem_fire;
    @(negedge clk);
    imem_req_ready = rrdy; inst_ready = irdy; redirect_valid = rv; redirect_pc = rpc; halt = hlt;
    rsp = mem_pend && (mem_cnt == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? memf(mem_addr) : $urandom;
    #1;
    hp      = !m_halted && (hlt || m_hpend);
    mis     = rv && (rpc[1:0] != 2'b00);
    red     = rv && !mis;
    exp_req = !m_halted && !m_out && !m_deliv && !hp;
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", inst_valid, m_deliv);
    if (m_deliv) begin
      chk("inst", inst, memf(d_pc));
      chk("inst_pc", inst_pc, d_pc);
      chk("inst_pc4", inst_pc4, d_pc + 32'd4);
    end
    chk("fetch_count", fetch_count, m_cnt);
    chk("halted", halted, m_halted);
    chk("err_misalign", err_misalign, m_err);
    if (m_err) chk("err_pc", err_pc, m_errpc);

    req_fire  = exp_req && rrdy;
    inst_fire = m_deliv && irdy;
    if (inst_fire) hs_seen++;
    if (!m_halted) begin
      idle = !m_out && !m_deliv;
      if (hlt) m_hpend = 1;
      if (inst_fire) m_cnt++;
      if (mis) begin
        m_err = 1; m_errpc = rpc; m_halted = 1; m_deliv = 0;
      end else begin
        if (m_deliv) begin
          if (inst_fire) begin
            m_deliv = 0;
            m_pc = d_pc + 32'd4;
            if (hp && !red) m_halted = 1;
          end else if (red) m_deliv = 0;
        end
        if (rsp && m_out) begin
          m_out = 0;
          if (hp && !red) m_halted = 1;
          else if (!m_stale && !red) begin m_deliv = 1; d_pc = m_addr; end
        end
        if (req_fire) begin m_out = 1; m_addr = m_pc; m_stale = 0; end
        if (red && m_out) m_stale = 1;
        if (hp && !red && idle) m_halted = 1;
        if (red) m_pc = rpc;
      end
    end

    mem_fire = imem_req_valid && rrdy;
    if (rsp) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (mem_fire) begin mem_pend = 1; mem_cnt = lat - 1; mem_addr = imem_req_addr; end
  endtask

  initial begin
    logic [31:0] i0, p0, c0;
    bit seen;
    lat = 2;

    // Straight-line fetch of three instructions.
    do_reset();
    for (int k = 0; k < 40 && hs_seen < 3; k++) cyc(1, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("t1_count3", fetch_count, 3);

    // Decode stall for five cycles in HOLD.
    for (int k = 0; k < 40; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (inst_valid) break;
    end
    chk("t2_valid", inst_valid, 1);
    i0 = inst; p0 = inst_pc; c0 = fetch_count;
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0, 0);
      chk("t2_inst_stable", inst, i0);
      chk("t2_pc_stable", inst_pc, p0);
      chk("t2_no_req", imem_req_valid, 0);
    end
    cyc(1, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("t2_count", fetch_count, c0 + 1);
    chk("t2_next_addr", imem_req_addr, p0 + 32'd4);

    // Redirect while waiting for the response of 0x80000004.
    do_reset();
    lat = 3;
    for (int k = 0; k < 40; k++) begin
      if (m_out && m_addr == RPC + 32'd4) break;
      cyc(1, 1, 0, 0, 0);
    end
    cyc(1, 1, 1, 32'h8000_0100, 0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1, 1, 0, 0, 0);
      if (inst_valid) seen = 1;
      if (imem_req_valid) break;
    end
    chk("t3_no_inst", seen, 0);
    chk("t3_addr", imem_req_addr, 32'h8000_0100);

    // Redirect coinciding with the decode handshake.
    do_reset();
    lat = 2;
    for (int k = 0; k < 40; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (inst_valid) break;
    end
    chk("t4_inst_pc", inst_pc, RPC);
    c0 = fetch_count;
    cyc(1, 1, 1, 32'h8000_0200, 0);
    @(posedge clk); #1;
    chk("t4_count", fetch_count, c0 + 1);
    chk("t4_req_valid", imem_req_valid, 1);
    chk("t4_addr", imem_req_addr, 32'h8000_0200);

    // Misaligned redirect halts with error.
    cyc(0, 0, 1, 32'h8000_0102, 0);
    @(posedge clk); #1;
    chk("t5_err", err_misalign, 1);
    chk("t5_err_pc", err_pc, 32'h8000_0102);
    chk("t5_halted", halted, 1);
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0);
    do_reset();

    // Halt while a fetch is outstanding.
    lat = 3;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1, 1, 0, 0, 0);
      if (inst_valid) seen = 1;
      if (halted) break;
    end
    chk("t6_halted", halted, 1);
    chk("t6_no_inst", seen, 0);

    // PC wrap from 0xFFFFFFFC.
    do_reset();
    lat = 2;
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
    for (int k = 0; k < 20 && hs_seen < 1; k++) cyc(1, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("t7_wrap_valid", imem_req_valid, 1);
    chk("t7_wrap_addr", imem_req_addr, 32'd0);

    // Randomized traffic with aligned redirects.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] rp;
      lat = $urandom_range(1, 3);
      rp = ($urandom % 16 == 0) ? 32'hFFFF_FFFC : RPC + ($urandom_range(0, 63) << 2);
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 12) == 0, rp, 0);
    end
    chk("rand_count", fetch_count, m_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Multi-cycle instruction-fetch sequencer that owns the architectural PC and replaces the free-running single-cycle PC update.
- Issues one fetch at a time to instruction memory over a valid/ready request channel and waits for the response.
- Presents the fetched instruction to decode with a valid/ready handshake.
- Applies redirects (taken branch, JAL, JALR targets) from execute, discarding any stale in-flight fetch.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- CNT_W, 32, width of the delivered-instruction counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address (equals pc)
- imem_rsp_valid  input  1  fetch response valid (single-cycle pulse, always accepted)
- imem_rsp_data  input  32  fetched instruction word
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode consumes instruction
- inst  output  32  instruction word
- inst_pc  output  32  address of inst
- inst_pc4  output  32  inst_pc + 4 (link value for JAL/JALR)
- redirect_valid  input  1  execute requests PC change
- redirect_pc  input  32  new PC; JALR bit0 already cleared upstream
- halt  input  1  stop fetching (ebreak); sticky until reset
- halted  output  1  controller in HALT
- err_misalign  output  1  sticky: redirect to address with pc[1:0] != 0
- err_pc  output  32  offending redirect_pc
- fetch_count  output  CNT_W  number of completed inst handshakes

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=REQ, drop=0, inst=0, inst_pc=0, fetch_count=0, err_misalign=0, err_pc=0.
  - All valid outputs are 0 while rst is high.
- States: REQ, WAIT, HOLD, HALT. Only one fetch is outstanding at any time.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready, go to WAIT.
  - Address stays stable while stalled, except on a redirect: pc updates and the request retargets the next cycle.
- WAIT:
  - On imem_rsp_valid with drop=0: latch inst=imem_rsp_data, inst_pc=pc; go to HOLD. inst_valid rises the cycle after the response (1-cycle latency).
  - On imem_rsp_valid with drop=1: discard data, clear drop, go to REQ.
- HOLD:
  - inst_valid=1. inst, inst_pc and inst_pc4 are held stable until the handshake.
  - On inst_ready: fetch_count+=1 (wrapping), pc<=pc+4 (mod 2^32, 0xFFFFFFFC wraps to 0), go to REQ.
- Redirect (checked every cycle outside HALT; highest priority for pc): pc<=redirect_pc, then by state:
  - REQ without handshake: stay in REQ.
  - REQ with handshake in the same cycle: go to WAIT with drop=1.
  - WAIT without response: drop=1.
  - WAIT with response in the same cycle: discard the response, go to REQ.
  - HOLD without inst_ready: inst is squashed (inst_valid=0 next cycle), go to REQ, fetch_count unchanged.
  - HOLD with inst_ready in the same cycle: the handshake completes and fetch_count increments, but pc=redirect_pc (redirect beats +4); go to REQ.
- Misaligned redirect (redirect_pc[1:0]!=0): set err_misalign=1 and err_pc=redirect_pc; go to HALT; pc is not updated.
- halt:
  - Sampled when high in REQ (before handshake) or in HOLD (after the inst_ready handshake, or immediately if no instruction is pending): go to HALT.
  - In WAIT: wait for the response, discard it, then go to HALT.
  - A latched halt request persists until it is acted on.
- HALT: all valids 0, pc frozen, halted=1. Only rst exits.
- Priority in any cycle: rst > misaligned redirect > redirect > halt > normal transitions.

Test Plan:
- Reset, memory ready=1 with 2-cycle response, decode ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008; inst_pc matches each; fetch_count=3 after three handshakes.
- inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, no new imem_req_valid; then ready=1 -> fetch_count+1, next address pc+4.
- Redirect to 0x80000100 while in WAIT -> the response for 0x80000004 is discarded (no inst_valid); next request address is 0x80000100.
- Redirect to 0x80000200 in the same cycle as the inst_ready handshake of inst_pc 0x80000000 -> fetch_count increments; next request address is 0x80000200, not 0x80000004.
- Redirect to 0x80000102 -> err_misalign=1, err_pc=0x80000102, halted=1, no further requests; rst clears all three.
- halt asserted in WAIT -> the response arrives and is dropped, halted=1 the next cycle, inst_valid never asserts; pc=0xFFFFFFFC fetch handshake -> next address 0x00000000.
